// File: rtl/des_pkg.sv
// Shared definitions for the DES wrapper and the blocks that drive it:
// command codes, region width and data width.
package des_pkg;

    localparam int REGION_W = 16;
    localparam int DATA_W   = 64;
    localparam int CMD_W    = 32;

    localparam logic [CMD_W-1:0] CMD_REGION  = 32'd0;
    localparam logic [CMD_W-1:0] CMD_START   = 32'd1;
    localparam logic [CMD_W-1:0] CMD_TEST    = 32'd2;
    localparam logic [CMD_W-1:0] CMD_RESTART = 32'd3;

    // One finished job as seen by the host.
    typedef struct packed {
        logic [DATA_W-1:0] counter;
        logic [DATA_W-1:0] ciphertext;
        logic              error;
    } des_result_t;

endpackage

// File: rtl/des_timeout_cnt.sv
// 32-bit cycle counter with synchronous clear and an expiry flag.
// expire_o is high during the cycle whose closing edge brings the count
// to LIMIT; LIMIT == 0 disables expiry entirely.
module des_timeout_cnt #(
    parameter logic [31:0] LIMIT = 32'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Next count: clear wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 32'd0;
        end else if (en_i) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (LIMIT != 32'd0) && en_i && !clr_i && (cnt_q == LIMIT - 32'd1);

endmodule

// File: rtl/des_cmd_master.sv
// Sequences one DES job: sends region and start commands to the wrapper,
// waits for done (optionally bounded by a timeout), captures the result,
// restarts the wrapper and hands the result to the host.
module des_cmd_master
    import des_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid,
    input  logic [REGION_W-1:0] job_region,
    output logic                job_ready,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [DATA_W-1:0]   result_counter,
    output logic [DATA_W-1:0]   result_ciphertext,
    output logic                result_error,
    output logic [CMD_W-1:0]    cmd,
    output logic                cmd_valid,
    output logic [31:0]         region,
    output logic                advance_test_cmd,
    input  logic                cmd_read,
    input  logic                done,
    input  logic [DATA_W-1:0]   counter,
    input  logic [DATA_W-1:0]   ciphertext
);

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_SEND_REGION  = 3'd1;
    localparam logic [2:0] ST_SEND_START   = 3'd2;
    localparam logic [2:0] ST_WAIT_DONE    = 3'd3;
    localparam logic [2:0] ST_CAPTURE      = 3'd4;
    localparam logic [2:0] ST_SEND_RESTART = 3'd5;
    localparam logic [2:0] ST_RESULT       = 3'd6;
    localparam logic [2:0] ST_ERROR        = 3'd7;

    logic [2:0]        state_q,     state_d;
    logic              job_ready_q, job_ready_d;
    logic [CMD_W-1:0]  cmd_q,       cmd_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [31:0]       region_q,    region_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_cnt_q,   res_cnt_d;
    logic [DATA_W-1:0] res_ct_q,    res_ct_d;
    logic              res_err_q,   res_err_d;

    logic cmd_taken;
    logic to_clr;
    logic to_en;
    logic to_expire;

    // A command is consumed only on an edge where it is actually offered.
    assign cmd_taken = cmd_valid_q && cmd_read;
    assign to_clr    = (state_q == ST_SEND_START) && cmd_taken;
    assign to_en     = (state_q == ST_WAIT_DONE);

    des_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (to_clr),
        .en_i    (to_en),
        .expire_o(to_expire)
    );

    // Next-state and registered-output logic of the job sequencer.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        region_d    = region_q;
        res_valid_d = res_valid_q;
        res_cnt_d   = res_cnt_q;
        res_ct_d    = res_ct_q;
        res_err_d   = res_err_q;

        case (state_q)
            ST_IDLE: begin
                if (job_valid && job_ready_q) begin
                    region_d    = {16'h0, job_region};
                    cmd_d       = CMD_REGION;
                    cmd_valid_d = 1'b1;
                    state_d     = ST_SEND_REGION;
                end
            end
            ST_SEND_REGION: begin
                // Drop valid on the consuming edge; start goes out one cycle later.
                if (cmd_taken) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_SEND_START;
                end
            end
            ST_SEND_START: begin
                if (!cmd_valid_q) begin
                    cmd_d       = CMD_START;
                    cmd_valid_d = 1'b1;
                end else if (cmd_read) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // done has priority over a timeout expiring on the same edge.
                if (done) begin
                    state_d = ST_CAPTURE;
                end else if (to_expire) begin
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    res_cnt_d   = '0;
                    res_ct_d    = '0;
                    state_d     = ST_ERROR;
                end
            end
            ST_CAPTURE: begin
                // The wrapper's counter settles one cycle after done rises.
                res_cnt_d   = counter;
                res_ct_d    = ciphertext;
                res_err_d   = 1'b0;
                cmd_d       = CMD_RESTART;
                cmd_valid_d = 1'b1;
                state_d     = ST_SEND_RESTART;
            end
            ST_SEND_RESTART: begin
                if (cmd_taken) begin
                    cmd_valid_d = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = ST_RESULT;
                end
            end
            ST_RESULT: begin
                if (result_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_ERROR: begin
                // The wrapper cannot be restarted from here; only rst leaves.
                if (result_ready) begin
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // job_ready is registered, so it reads 0 in the first cycle after reset.
    assign job_ready_d = (state_d == ST_IDLE);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            job_ready_q <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            region_q    <= '0;
            res_valid_q <= 1'b0;
            res_cnt_q   <= '0;
            res_ct_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_ready_q <= job_ready_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            region_q    <= region_d;
            res_valid_q <= res_valid_d;
            res_cnt_q   <= res_cnt_d;
            res_ct_q    <= res_ct_d;
            res_err_q   <= res_err_d;
        end
    end

    assign job_ready         = job_ready_q;
    assign result_valid      = res_valid_q;
    assign result_counter    = res_cnt_q;
    assign result_ciphertext = res_ct_q;
    assign result_error      = res_err_q;
    assign cmd               = cmd_q;
    assign cmd_valid         = cmd_valid_q;
    assign region            = region_q;
    assign advance_test_cmd  = 1'b0;

endmodule

// File: tb/tb_des_cmd_master.sv
// Bench for des_cmd_master: one instance without timeout, one with a
// 50-cycle timeout, a behavioural DES wrapper and a result scoreboard.
module tb_des_cmd_master;
    import des_pkg::*;

    typedef struct {
        logic [63:0] c;
        logic [63:0] t;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        job_valid = 1'b0;
    logic [15:0] job_region = '0;
    logic        result_ready = 1'b0;
    logic        cmd_read = 1'b0;
    logic        done = 1'b0;
    logic [63:0] w_counter = '0;
    logic [63:0] w_cipher = '0;
    bit          sel = 1'b0;

    logic        d0_job_ready, d0_result_valid, d0_result_error, d0_cmd_valid, d0_adv;
    logic [63:0] d0_result_counter, d0_result_ciphertext;
    logic [31:0] d0_cmd, d0_region;
    logic        d5_job_ready, d5_result_valid, d5_result_error, d5_cmd_valid, d5_adv;
    logic [63:0] d5_result_counter, d5_result_ciphertext;
    logic [31:0] d5_cmd, d5_region;

    logic        s_job_ready, s_result_valid, s_result_error, s_cmd_valid, s_adv;
    logic [63:0] s_result_counter, s_result_ciphertext;
    logic [31:0] s_cmd, s_region;

    int          checks = 0;
    int          failures = 0;
    int          pcyc = 0;
    int          start_cyc = 0;
    int          start_cnt = 0;
    int          viol = 0;
    int          m_rd = 1;
    int          m_dd = 0;
    logic [63:0] m_ctr = '0;
    logic [63:0] m_ct = '0;
    logic [31:0] cmd_log[$];
    exp_t        sb[$];
    logic [31:0] exp_cmd[3];

    des_cmd_master u_dut0 (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_region(job_region),
        .job_ready(d0_job_ready), .result_valid(d0_result_valid), .result_ready(result_ready),
        .result_counter(d0_result_counter), .result_ciphertext(d0_result_ciphertext),
        .result_error(d0_result_error), .cmd(d0_cmd), .cmd_valid(d0_cmd_valid),
        .region(d0_region), .advance_test_cmd(d0_adv), .cmd_read(cmd_read), .done(done),
        .counter(w_counter), .ciphertext(w_cipher)
    );

    des_cmd_master #(.TIMEOUT_CYCLES(32'd50)) u_dut5 (
        .clk(clk), .rst(rst), .job_valid(job_valid), .job_region(job_region),
        .job_ready(d5_job_ready), .result_valid(d5_result_valid), .result_ready(result_ready),
        .result_counter(d5_result_counter), .result_ciphertext(d5_result_ciphertext),
        .result_error(d5_result_error), .cmd(d5_cmd), .cmd_valid(d5_cmd_valid),
        .region(d5_region), .advance_test_cmd(d5_adv), .cmd_read(cmd_read), .done(done),
        .counter(w_counter), .ciphertext(w_cipher)
    );

    assign s_job_ready         = sel ? d5_job_ready         : d0_job_ready;
    assign s_result_valid      = sel ? d5_result_valid      : d0_result_valid;
    assign s_result_error      = sel ? d5_result_error      : d0_result_error;
    assign s_result_counter    = sel ? d5_result_counter    : d0_result_counter;
    assign s_result_ciphertext = sel ? d5_result_ciphertext : d0_result_ciphertext;
    assign s_cmd               = sel ? d5_cmd               : d0_cmd;
    assign s_cmd_valid         = sel ? d5_cmd_valid         : d0_cmd_valid;
    assign s_region            = sel ? d5_region            : d0_region;
    assign s_adv               = sel ? d5_adv               : d0_adv;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        pcyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural DES wrapper: delayed cmd_read, done after m_dd cycles,
    // counter/ciphertext valid one cycle after done rises.
    initial begin : wrapper_model
        int          wcnt;
        int          dcnt;
        bit          cpend;
        bit          pv;
        bit          pr;
        logic [31:0] pc;
        wcnt = 0; dcnt = 0; cpend = 0; pv = 0; pr = 0; pc = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wcnt = 0; dcnt = 0; cpend = 0; pv = 0; pr = 0; pc = '0;
                cmd_read = 1'b0;
                done = 1'b0;
            end else begin
                if (pv && pr) begin
                    cmd_log.push_back(pc);
                    if (s_cmd_valid) viol++;
                    if (pc == CMD_START) begin
                        start_cyc = pcyc;
                        start_cnt++;
                        dcnt = m_dd;
                        w_counter = 64'hDEAD_BEEF_DEAD_BEEF;
                        w_cipher = 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                    if (pc == CMD_RESTART) done = 1'b0;
                end else if (pv && !(s_cmd_valid && s_cmd == pc)) begin
                    viol++;
                end
                if (cpend) begin
                    w_counter = m_ctr;
                    w_cipher = m_ct;
                    cpend = 0;
                end
                if (dcnt > 0) begin
                    dcnt--;
                    if (dcnt == 0) begin
                        done = 1'b1;
                        cpend = 1;
                    end
                end
                if (s_cmd_valid) begin
                    wcnt++;
                    cmd_read = (wcnt > m_rd);
                end else begin
                    wcnt = 0;
                    cmd_read = 1'b0;
                end
                pv = s_cmd_valid;
                pr = cmd_read;
                pc = s_cmd;
            end
        end
    end

    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        rst = 1'b1;
        job_valid = 1'b0;
        result_ready = 1'b0;
        @(posedge clk);
        #1;
        check({nm, "_job_ready0"}, s_job_ready, 1'b0);
        check({nm, "_cmd_valid"}, s_cmd_valid, 1'b0);
        check({nm, "_cmd"}, s_cmd, 32'd0);
        check({nm, "_region"}, s_region, 32'd0);
        check({nm, "_result_valid"}, s_result_valid, 1'b0);
        check({nm, "_result_error"}, s_result_error, 1'b0);
        check({nm, "_result_counter"}, s_result_counter, 64'd0);
        check({nm, "_result_cipher"}, s_result_ciphertext, 64'd0);
        rst = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        check({nm, "_job_ready1"}, s_job_ready, 1'b1);
    endtask

    task automatic accept_job(input string nm, input logic [15:0] rg);
        int n;
        n = 0;
        @(negedge clk);
        while (!s_job_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_accept_ready"}, s_job_ready, 1'b1);
        job_region = rg;
        job_valid = 1'b1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        check({nm, "_first_cmd"}, {s_cmd_valid, s_cmd}, {1'b1, CMD_REGION});
    endtask

    task automatic run_job(input bit which, input logic [15:0] rg, input int rd, input int dd,
                           input logic [63:0] ctr, input logic [63:0] ct, input bit exp_err,
                           input int hold, input int exp_lat, input string nm);
        int          n;
        int          bad;
        int          vbase;
        int          ncmd;
        exp_t        e;
        logic [63:0] sc;
        logic [63:0] st;
        logic        se;
        sel = which;
        m_rd = rd;
        m_dd = dd;
        m_ctr = ctr;
        m_ct = ct;
        cmd_log.delete();
        vbase = viol;
        e.c = exp_err ? 64'd0 : ctr;
        e.t = exp_err ? 64'd0 : ct;
        e.err = exp_err;
        sb.push_back(e);
        accept_job(nm, rg);
        n = 0;
        while (!s_result_valid && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({nm, "_result_valid"}, s_result_valid, 1'b1);
        if (exp_lat >= 0) check({nm, "_latency"}, 64'(pcyc - start_cyc), 64'(exp_lat));
        sc = s_result_counter;
        st = s_result_ciphertext;
        se = s_result_error;
        job_valid = 1'b1;
        job_region = ~rg;
        bad = 0;
        repeat (hold) begin
            @(posedge clk);
            #1;
            if (!s_result_valid || s_job_ready || s_result_counter !== sc ||
                s_result_ciphertext !== st || s_result_error !== se) bad++;
        end
        check({nm, "_hold"}, 64'(bad), 64'd0);
        check({nm, "_region"}, s_region, {16'h0, rg});
        result_ready = 1'b1;
        check({nm, "_sb_nonempty"}, 64'(sb.size()), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({nm, "_counter"}, s_result_counter, e.c);
            check({nm, "_cipher"}, s_result_ciphertext, e.t);
            check({nm, "_error"}, s_result_error, e.err);
        end
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        job_valid = 1'b0;
        check({nm, "_rv_cleared"}, s_result_valid, 1'b0);
        check({nm, "_job_ready_after"}, s_job_ready, !exp_err);
        ncmd = exp_err ? 2 : 3;
        check({nm, "_cmd_count"}, 64'(cmd_log.size()), 64'(ncmd));
        for (int i = 0; i < ncmd; i++) begin
            if (i < cmd_log.size()) check({nm, "_cmd_order"}, cmd_log[i], exp_cmd[i]);
        end
        check({nm, "_cmd_stable"}, 64'(viol - vbase), 64'd0);
    endtask

    initial begin : main
        int          bad;
        int          n;
        int          rd_r;
        int          dd_r;
        logic [63:0] c;
        exp_cmd[0] = CMD_REGION;
        exp_cmd[1] = CMD_START;
        exp_cmd[2] = CMD_RESTART;

        sel = 1'b0;
        do_reset("reset0");
        check("adv_test_tied", s_adv, 1'b0);

        run_job(1'b0, 16'h0005, 1, 100, 64'h2A, 64'h0123_4567_89AB_CDEF, 1'b0, 0, 103, "basic");
        run_job(1'b0, 16'hBEEF, 5, 20, 64'hCAFE_F00D_0000_0001, 64'h55AA_55AA_1234_5678, 1'b0, 0, 27, "slowrd");
        run_job(1'b0, 16'h0A0A, 2, 7, 64'h1111_2222_3333_4444, 64'h9999_8888_7777_6666, 1'b0, 10, 11, "hold");
        for (int k = 0; k < 3; k++) begin
            rd_r = int'($urandom_range(0, 3));
            dd_r = int'($urandom_range(1, 30));
            c = {$urandom, $urandom};
            run_job(1'b0, 16'($urandom), rd_r, dd_r, c, ~c, 1'b0, k, dd_r + 2 + rd_r, "rnd");
        end

        // Abandon a job in WAIT_DONE by reset, then run a clean job.
        m_rd = 1;
        m_dd = 0;
        cmd_log.delete();
        n = start_cnt;
        accept_job("midrst", 16'h0042);
        bad = 0;
        while (start_cnt == n && bad < 50) begin
            @(posedge clk);
            #1;
            bad++;
        end
        check("midrst_started", 64'(start_cnt - n), 64'd1);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_waiting", s_cmd_valid, 1'b0);
        do_reset("midrst");
        run_job(1'b0, 16'h0077, 1, 12, 64'h7777_0000_7777_0000, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 2, 15, "after_rst");

        // Timeout instance.
        sel = 1'b1;
        do_reset("reset5");
        run_job(1'b1, 16'h0050, 1, 50, 64'h5050_5050_5050_5050, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 1, 53, "done_at_expiry");
        run_job(1'b1, 16'h0049, 0, 49, 64'h4949, 64'h9494, 1'b0, 0, 51, "done_before");
        run_job(1'b1, 16'h00EE, 1, 0, 64'h0, 64'h0, 1'b1, 3, 50, "timeout");

        job_valid = 1'b1;
        job_region = 16'h7777;
        bad = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (s_job_ready || s_cmd_valid || s_result_valid || !s_result_error) bad++;
        end
        job_valid = 1'b0;
        check("error_stuck", 64'(bad), 64'd0);

        do_reset("err_rst");
        run_job(1'b1, 16'h1234, 1, 10, 64'hABCD_0000_0000_1234, 64'h1357_9BDF_2468_ACE0, 1'b0, 0, 13, "post_err");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
